// File: rtl/ams_video_pkg.sv
// ams_video_pkg: screen mode encodings and per-mode pixel shift table
package ams_video_pkg;
    typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} mode_t;
    // pixel index k = phase >> MODE_SHIFT[mode]: mode 0/3 = 2 px/byte, mode 1 = 4, mode 2 = 8
    localparam logic [1:0] MODE_SHIFT [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
endpackage

// File: rtl/pen_palette.sv
// pen_palette: pen colour table plus border entry, one write port and one write-first combinational read port
// Ports: clk, rst (sync, active-high, clears every entry); we/waddr/wdata write port;
//        raddr/rdata read port. Address MSB selects the border entry; MSB with nonzero low bits is not an entry.
module pen_palette #(
    parameter int PEN_W    = 4,
    parameter int COLOUR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [PEN_W:0]      waddr,
    input  logic [COLOUR_W-1:0] wdata,
    input  logic [PEN_W:0]      raddr,
    output logic [COLOUR_W-1:0] rdata
);
    logic [COLOUR_W-1:0] pens [2**PEN_W];
    logic [COLOUR_W-1:0] border;
    logic                wvalid;

    assign wvalid = !waddr[PEN_W] || waddr[PEN_W-1:0] == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**PEN_W; i++) pens[i] <= '0;
            border <= '0;
        end else if (we && wvalid) begin
            if (waddr[PEN_W]) border <= wdata;
            else pens[waddr[PEN_W-1:0]] <= wdata;
        end
    end

    // a write to the entry being read is visible in the same cycle
    assign rdata = (!rst && we && wvalid && waddr == raddr) ? wdata
                 : raddr[PEN_W] ? border : pens[raddr[PEN_W-1:0]];
endmodule

// File: rtl/video_pixel_engine.sv
// video_pixel_engine: serialises fetched video bytes into palette colours at the pixel-slot rate
// Ports: CLK_n clock, RESET sync active-high; PIX_EN pixel slot enable; LOAD/VIDEO/DISPEN byte load;
//        MODE/MODE_SYNC mode update; PAL_WE/PAL_ADDR/PAL_DATA palette write; COLOUR/BORDER_ACT registered output.
module video_pixel_engine
    import ams_video_pkg::*;
#(
    parameter int PEN_W    = 4,
    parameter int COLOUR_W = 5
) (
    input  logic                CLK_n,
    input  logic                RESET,
    input  logic                PIX_EN,
    input  logic                LOAD,
    input  logic [7:0]          VIDEO,
    input  logic                DISPEN,
    input  logic [1:0]          MODE,
    input  logic                MODE_SYNC,
    input  logic                PAL_WE,
    input  logic [PEN_W:0]      PAL_ADDR,
    input  logic [COLOUR_W-1:0] PAL_DATA,
    output logic [COLOUR_W-1:0] COLOUR,
    output logic                BORDER_ACT
);
    mode_t               mode_r;
    logic [7:0]          byte_r;
    logic                border_f;
    logic [2:0]          phase;
    logic [2:0]          k;
    logic [3:0]          pen_full;
    logic [PEN_W-1:0]    pen;
    logic [PEN_W:0]      raddr;
    logic [COLOUR_W-1:0] rdata;

    assign k = phase >> MODE_SHIFT[mode_r];
    // bit indices wrap in 3 bits; only modes that reach a given k use the matching bits
    assign pen_full = {mode_r == MODE0 && byte_r[3'd1 - k],
                       mode_r == MODE0 && byte_r[3'd5 - k],
                       mode_r != MODE2 && byte_r[3'd3 - k],
                       byte_r[3'd7 - k]};
    assign pen = pen_full[PEN_W-1:0];
    // border entry lives at address {1, 0...}
    assign raddr = {border_f, pen & {PEN_W{!border_f}}};

    pen_palette #(.PEN_W(PEN_W), .COLOUR_W(COLOUR_W)) u_pal (
        .clk   (CLK_n),
        .rst   (RESET),
        .we    (PAL_WE),
        .waddr (PAL_ADDR),
        .wdata (PAL_DATA),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            COLOUR     <= '0;
            BORDER_ACT <= 1'b0;
            phase      <= '0;
            byte_r     <= '0;
            border_f   <= 1'b1;
            mode_r     <= MODE1;
        end else begin
            if (MODE_SYNC) mode_r <= mode_t'(MODE);
            if (PIX_EN) begin
                COLOUR     <= rdata;
                BORDER_ACT <= border_f;
                if (LOAD) begin
                    byte_r   <= DISPEN ? VIDEO : 8'h00;
                    border_f <= !DISPEN;
                    phase    <= '0;
                end else begin
                    phase <= phase + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_pixel_engine.sv
// tb_video_pixel_engine: directed vector bench for video_pixel_engine
module tb_video_pixel_engine;
    logic       CLK_n = 1'b0;
    logic       RESET, PIX_EN, LOAD, DISPEN, MODE_SYNC, PAL_WE;
    logic [7:0] VIDEO;
    logic [1:0] MODE;
    logic [4:0] PAL_ADDR, PAL_DATA, COLOUR;
    logic       BORDER_ACT;
    int         applied = 0;
    int         miscompares = 0;

    typedef struct {
        logic       rst, pe, ld;
        logic [7:0] vid;
        logic       de;
        logic [1:0] md;
        logic       ms, we;
        logic [4:0] pa, pd, col;
        logic       ba;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK_n = ~CLK_n;

    video_pixel_engine #(.PEN_W(4), .COLOUR_W(5)) dut (
        .CLK_n      (CLK_n),
        .RESET      (RESET),
        .PIX_EN     (PIX_EN),
        .LOAD       (LOAD),
        .VIDEO      (VIDEO),
        .DISPEN     (DISPEN),
        .MODE       (MODE),
        .MODE_SYNC  (MODE_SYNC),
        .PAL_WE     (PAL_WE),
        .PAL_ADDR   (PAL_ADDR),
        .PAL_DATA   (PAL_DATA),
        .COLOUR     (COLOUR),
        .BORDER_ACT (BORDER_ACT)
    );

    function automatic vec_t v(input logic rst, pe, ld, input logic [7:0] vid, input logic de,
                               input logic [1:0] md, input logic ms, we, input logic [4:0] pa, pd, col,
                               input logic ba);
        vec_t t;
        t.rst = rst; t.pe = pe; t.ld = ld; t.vid = vid; t.de = de; t.md = md;
        t.ms = ms; t.we = we; t.pa = pa; t.pd = pd; t.col = col; t.ba = ba;
        return t;
    endfunction

    function automatic vec_t px(input logic [4:0] col, input logic ba);
        return v(0, 1, 0, 8'h00, 0, 2'd0, 0, 0, 5'h00, 5'h00, col, ba);
    endfunction

    function automatic vec_t ld(input logic [7:0] vid, input logic de, input logic [4:0] col, input logic ba);
        return v(0, 1, 1, vid, de, 2'd0, 0, 0, 5'h00, 5'h00, col, ba);
    endfunction

    function automatic vec_t wr(input logic [4:0] pa, pd, col, input logic ba);
        return v(0, 0, 0, 8'h00, 0, 2'd0, 0, 1, pa, pd, col, ba);
    endfunction

    function automatic vec_t ms(input logic [1:0] md, input logic [4:0] col, input logic ba);
        return v(0, 0, 0, 8'h00, 0, md, 1, 0, 5'h00, 5'h00, col, ba);
    endfunction

    function automatic vec_t hold(input logic [4:0] col, input logic ba);
        return v(0, 0, 0, 8'h00, 0, 2'd0, 0, 0, 5'h00, 5'h00, col, ba);
    endfunction

    task automatic apply(input vec_t t, input string tag);
        @(negedge CLK_n);
        RESET = t.rst; PIX_EN = t.pe; LOAD = t.ld; VIDEO = t.vid; DISPEN = t.de;
        MODE = t.md; MODE_SYNC = t.ms; PAL_WE = t.we; PAL_ADDR = t.pa; PAL_DATA = t.pd;
        @(posedge CLK_n);
        #1;
        applied++;
        if (COLOUR !== t.col || BORDER_ACT !== t.ba) begin
            miscompares++;
            $display("FAIL %s vec %0d: COLOUR=%h BORDER_ACT=%b, expected COLOUR=%h BORDER_ACT=%b",
                     tag, applied, COLOUR, BORDER_ACT, t.col, t.ba);
        end
    endtask

    initial begin
        RESET = 1; PIX_EN = 0; LOAD = 0; VIDEO = 0; DISPEN = 0;
        MODE = 0; MODE_SYNC = 0; PAL_WE = 0; PAL_ADDR = 0; PAL_DATA = 0;

        // reset state
        apply(v(1, 1, 1, 8'hFF, 1, 2'd0, 1, 1, 5'h10, 5'h1F, 5'h00, 0), "reset");
        apply(v(1, 0, 0, 8'h00, 0, 2'd0, 0, 0, 5'h00, 5'h00, 5'h00, 0), "reset");

        // mode 2, 0xA5, with hold and wrap; invalid border write ignored
        vecs.push_back(wr(5'h00, 5'h04, 5'h00, 0));
        vecs.push_back(wr(5'h01, 5'h1A, 5'h00, 0));
        vecs.push_back(ms(2'd2, 5'h00, 0));
        vecs.push_back(wr(5'h13, 5'h1F, 5'h00, 0));
        vecs.push_back(ld(8'hA5, 1, 5'h00, 1));
        vecs.push_back(px(5'h1A, 0));
        vecs.push_back(px(5'h04, 0));
        vecs.push_back(px(5'h1A, 0));
        vecs.push_back(hold(5'h1A, 0));
        vecs.push_back(px(5'h04, 0));
        vecs.push_back(px(5'h04, 0));
        vecs.push_back(px(5'h1A, 0));
        vecs.push_back(px(5'h04, 0));
        vecs.push_back(px(5'h1A, 0));
        vecs.push_back(px(5'h1A, 0));
        vecs.push_back(px(5'h04, 0));
        // mode 0, 0x80
        vecs.push_back(wr(5'h01, 5'h0C, 5'h04, 0));
        vecs.push_back(wr(5'h00, 5'h00, 5'h04, 0));
        vecs.push_back(ms(2'd0, 5'h04, 0));
        vecs.push_back(ld(8'h80, 1, 5'h00, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(px(5'h0C, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(px(5'h00, 0));
        // DISPEN=0 shows border
        vecs.push_back(wr(5'h10, 5'h10, 5'h00, 0));
        vecs.push_back(ld(8'hFF, 0, 5'h0C, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(px(5'h10, 1));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "table");

        // write-first: pen 3 written in the slot it is displayed (mode 1, 0x88)
        apply(ms(2'd1, 5'h10, 1), "wr_first");
        apply(ld(8'h88, 1, 5'h10, 1), "wr_first");
        apply(v(0, 1, 0, 8'h00, 0, 2'd0, 0, 1, 5'h03, 5'h07, 5'h07, 0), "wr_first");
        apply(px(5'h07, 0), "wr_first");
        apply(px(5'h00, 0), "wr_first");

        // mode change mid-byte keeps the phase
        apply(ms(2'd2, 5'h00, 0), "mode_sync");
        apply(ld(8'h40, 1, 5'h00, 0), "mode_sync");
        apply(px(5'h00, 0), "mode_sync");
        apply(px(5'h0C, 0), "mode_sync");
        apply(px(5'h00, 0), "mode_sync");
        apply(px(5'h00, 0), "mode_sync");
        apply(ms(2'd0, 5'h00, 0), "mode_sync");
        for (int i = 0; i < 4; i++) apply(px(5'h0C, 0), "mode_sync");

        // reset mid-byte, with priority over load, mode sync and palette write
        apply(ld(8'h80, 1, 5'h00, 0), "mid_reset");
        apply(px(5'h0C, 0), "mid_reset");
        apply(px(5'h0C, 0), "mid_reset");
        apply(v(1, 1, 1, 8'hFF, 1, 2'd2, 1, 1, 5'h03, 5'h1F, 5'h00, 0), "mid_reset");
        apply(px(5'h00, 1), "mid_reset");
        apply(ld(8'hFF, 1, 5'h00, 1), "mid_reset");
        apply(px(5'h00, 0), "mid_reset");
        apply(px(5'h00, 0), "mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/video_pixel_engine.md
VIDEO_PIXEL_ENGINE -- requirements
Module: video_pixel_engine

Interface
REQ-001 SHALL have parameter PEN_W, default 4, meaning pen index width (2..4; 2**PEN_W pens).
REQ-002 SHALL have parameter COLOUR_W, default 5, meaning palette entry width (5 = hardware colour number, 12 = RGB444).
REQ-003 SHALL have port CLK_n  in  1  only clock, rising-edge active; one clock, all logic synchronous to it.
REQ-004 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port PIX_EN  in  1  pixel-rate enable, one per 16 MHz-equivalent pixel slot.
REQ-006 SHALL have port LOAD  in  1  video byte strobe, qualified by PIX_EN.
REQ-007 SHALL have port VIDEO  in  8  fetched video byte.
REQ-008 SHALL have port DISPEN  in  1  display enable, sampled with LOAD.
REQ-009 SHALL have port MODE  in  2  requested screen mode.
REQ-010 SHALL have port MODE_SYNC  in  1  mode-apply strobe.
REQ-011 SHALL have port PAL_WE  in  1  palette write strobe.
REQ-012 SHALL have port PAL_ADDR  in  PEN_W+1  pen address; MSB set = border entry.
REQ-013 SHALL have port PAL_DATA  in  COLOUR_W  palette write data.
REQ-014 SHALL have port COLOUR  out  COLOUR_W  registered pixel colour.
REQ-015 SHALL have port BORDER_ACT  out  1  COLOUR currently sourced from border entry.

Function
REQ-016 SHALL hold active mode register; copy MODE into it on any cycle with MODE_SYNC=1, independent of PIX_EN.
REQ-017 SHALL on PIX_EN&LOAD latch VIDEO (forced 0x00 if DISPEN=0), latch DISPEN as border flag, clear pixel phase counter to 0.
REQ-018 SHALL advance 3-bit phase counter on each PIX_EN without LOAD; wrap 7->0 without reload, repeating the held byte.
REQ-019 SHALL select pixel k = phase >> s, with s = 2 (mode 0), 1 (mode 1), 0 (mode 2), 2 (mode 3).
REQ-020 SHALL form pen bits: bit0 = VIDEO[7-k], bit1 = VIDEO[3-k] (modes 0,1,3), bit2 = VIDEO[5-k], bit3 = VIDEO[1-k] (mode 0 only); mode 2 uses bit0 only; unused bits 0; bits >= PEN_W dropped.
REQ-021 SHALL on each PIX_EN register COLOUR = palette[pen], or border entry when border flag set; BORDER_ACT registered alongside.
REQ-022 SHALL give latency: byte loaded at PIX_EN n appears as pixel 0 on COLOUR after PIX_EN n+1.
REQ-023 SHALL write PAL_DATA to PAL_ADDR on PAL_WE regardless of PIX_EN; same-cycle read of that entry returns new data (write-first).
REQ-024 SHALL ignore writes to PAL_ADDR with MSB set and nonzero low bits.
REQ-025 SHALL, on MODE_SYNC mid-byte, apply new mode from next PIX_EN using current phase (no realignment).
REQ-026 SHALL hold COLOUR and BORDER_ACT when PIX_EN=0.

Reset
REQ-027 SHALL on RESET clear COLOUR, BORDER_ACT, phase, held byte to 0; border flag to 1; active mode to 1.
REQ-028 SHALL clear all palette entries and border entry to 0 on RESET.
REQ-029 SHALL give RESET priority over LOAD, MODE_SYNC and PAL_WE in the same cycle.

Structure
REQ-030 SHALL place mode encodings (MODE0..MODE3) and per-mode shift table in shared package ams_video_pkg.
REQ-031 SHALL implement palette and border entry as sub-module pen_palette (write port + one combinational read port).

Verification
REQ-032 SHALL check mode 2, byte 0xA5, DISPEN=1, pal[0]=0x04, pal[1]=0x1A -> COLOUR 1A,04,1A,04,04,1A,04,1A on successive PIX_EN from n+1.
REQ-033 SHALL check mode 0, byte 0x80, pal[1]=0x0C, pal[0]=0x00 -> COLOUR 0C x4 then 00 x4.
REQ-034 SHALL check DISPEN=0 at LOAD, border=0x10 -> COLOUR 0x10, BORDER_ACT=1 for 8 PIX_EN.
REQ-035 SHALL check PAL_WE pen 3 <- 0x07 in same cycle pen 3 displayed (mode 1, byte 0x88) -> COLOUR 0x07 at that PIX_EN.
REQ-036 SHALL check MODE=0 with MODE_SYNC at phase 4 in mode 2 -> phases 4..7 use mode-0 pixel 1; RESET mid-byte -> COLOUR 0 next edge.
